// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values, FSM state
// encoding and flag bit positions.
package seq_alu_pkg;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_SLL  = 6;
    localparam int OP_SRL  = 7;
    localparam int OP_SRA  = 8;
    localparam int OP_SLT  = 9;
    localparam int OP_SLTU = 10;
    localparam int OP_MULU = 11;
    localparam int OP_MULS = 12;
    localparam int OP_DIVU = 13;
    localparam int OP_ROTL = 14;
    localparam int OP_LAST = 14;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ERR   = 3;
    localparam int FLAG_N     = 4;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath shared by unsigned shift-add multiply (mode=0) and
// restoring divide (mode=1). One bit per cycle, WIDTH cycles after start.
// Multiply: acc starts as {0, x}, y is the multiplicand; acc ends as x*y.
// Divide:   acc starts as {0, x}, y is the divisor; acc ends as {rem, quot}.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   acc
);

    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

    logic [SHW:0]         cnt;
    logic                 run;
    logic                 mode_q;
    logic [WIDTH-1:0]     y_q;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_new;
    logic                 ge;
    logic [2*WIDTH-1:0]   acc_next;

    assign busy = run && (cnt != CNT_LAST);
    assign done = run && (cnt == CNT_LAST);

    // One step of either algorithm, selected by the latched mode.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, y_q} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge       = (rem_sh >= {1'b0, y_q});
        rem_new  = ge ? (rem_sh - {1'b0, y_q}) : rem_sh;
        if (mode_q) begin
            acc_next = {rem_new[WIDTH-1:0], acc[WIDTH-2:0], ge};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Control: run flag and iteration counter, cleared on start and by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
        end else if (done) begin
            run <= 1'b0;
        end
    end

    // Datapath: load operands on start, then advance one bit per cycle.
    always_ff @(posedge clk) begin
        if (start) begin
            acc    <= {{WIDTH{1'b0}}, x};
            y_q    <= y;
            mode_q <= mode;
        end else if (busy) begin
            acc    <= acc_next;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes and status flags.
// Single-cycle ops go through EXEC; MULU/MULS and DIVU use seq_alu_iter.
// Build option SEQ_ALU_FAST_MUL_EN: multiplies use a combinational
// multiplier through EXEC instead of the iterative datapath.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [OPW-1:0]       op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_zero,
    output logic                 flag_carry,
    output logic                 flag_ovf,
    output logic                 flag_err
);

    state_t                    state, state_next;
    logic                      accept;
    logic [WIDTH-1:0]          a_q, b_q;
    logic [OPW-1:0]            op_q;
    logic signed [WIDTH-1:0]   a_s, b_s;
    logic [31:0]               op_cur, op_new;
    logic [SHW-1:0]            sh;
    logic [WIDTH:0]            sum;
    logic [WIDTH-1:0]          diff;
    logic [2*WIDTH-1:0]        rot;
    logic [WIDTH-1:0]          lo, hi;
    logic [FLAG_N-1:0]         exec_flags, iter_flags, flags_q;
    logic [2*WIDTH-1:0]        iter_acc, iter_res;
    logic                      iter_start, iter_mode, iter_busy, iter_done;
    logic [WIDTH-1:0]          iter_x, iter_y;

    assign op_cur = 32'(op_q);
    assign op_new = 32'(op);
    assign a_s    = a_q;
    assign b_s    = b_q;
    assign sh     = b_q[SHW-1:0];

    assign out_valid  = (state == S_DONE);
    assign flag_zero  = flags_q[FLAG_ZERO];
    assign flag_carry = flags_q[FLAG_CARRY];
    assign flag_ovf   = flags_q[FLAG_OVF];
    assign flag_err   = flags_q[FLAG_ERR];

    // Where a freshly accepted opcode goes; divide by zero is resolved in EXEC.
    function automatic state_t dispatch(input logic [31:0] opc, input logic b_zero);
        if (opc == OP_DIVU && !b_zero) return S_DIV;
`ifndef SEQ_ALU_FAST_MUL_EN
        if (opc == OP_MULU || opc == OP_MULS) return S_MUL;
`endif
        return S_EXEC;
    endfunction

    // Unsigned magnitude of an operand, two's-complement negated when signed and negative.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake and next-state logic; in_ready is held low during reset.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_IDLE:  in_ready = 1'b1;
            S_DONE:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        in_ready = in_ready && rst_n;
        accept   = in_valid && in_ready;
        case (state)
            S_IDLE: if (accept) state_next = dispatch(op_new, b == '0);
            S_EXEC: state_next = S_DONE;
            S_MUL, S_DIV: if (!iter_busy) state_next = S_DONE;
            S_DONE: begin
                if (accept) begin
                    state_next = dispatch(op_new, b == '0);
                end else if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture on acceptance; later input changes cannot reach the datapath.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
        end
    end

    // The iterative unit starts on the same edge that accepts the operation,
    // so it is fed from the live inputs rather than the operand registers.
    assign iter_start = accept && (state_next == S_MUL || state_next == S_DIV);
    assign iter_mode  = (state_next == S_DIV);
    assign iter_x     = iter_mode ? a : magnitude(b, op_new == OP_MULS);
    assign iter_y     = iter_mode ? b : magnitude(a, op_new == OP_MULS);

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (iter_start),
        .mode  (iter_mode),
        .x     (iter_x),
        .y     (iter_y),
        .busy  (iter_busy),
        .done  (iter_done),
        .acc   (iter_acc)
    );

    // Final iterative result: signed multiply restores the product sign.
    always_comb begin
        iter_res = iter_acc;
        if (state == S_MUL && op_cur == OP_MULS && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) begin
            iter_res = -iter_acc;
        end
        iter_flags            = '0;
        iter_flags[FLAG_ZERO] = (iter_res == '0);
    end

`ifdef SEQ_ALU_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] a_wide, b_wide, prod;

    // Combinational multiply on sign- or zero-extended operands; low 2*WIDTH bits are exact.
    always_comb begin
        if (op_cur == OP_MULS) begin
            a_wide = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            b_wide = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            a_wide = {{WIDTH{1'b0}}, a_q};
            b_wide = {{WIDTH{1'b0}}, b_q};
        end
        prod = a_wide * b_wide;
    end
`endif

    // Single-cycle result and flags computed from the registered operands.
    always_comb begin
        lo         = '0;
        hi         = '0;
        exec_flags = '0;
        sum        = {1'b0, a_q} + {1'b0, b_q};
        diff       = a_q - b_q;
        rot        = {a_q, a_q} << sh;
        case (op_cur)
            OP_ADD: begin
                lo                     = sum[WIDTH-1:0];
                exec_flags[FLAG_CARRY] = sum[WIDTH];
                exec_flags[FLAG_OVF]   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                lo                     = diff;
                exec_flags[FLAG_CARRY] = (a_q < b_q);
                exec_flags[FLAG_OVF]   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  lo = a_q & b_q;
            OP_OR:   lo = a_q | b_q;
            OP_XOR:  lo = a_q ^ b_q;
            OP_NOR:  lo = ~(a_q | b_q);
            OP_SLL:  lo = a_q << sh;
            OP_SRL:  lo = a_q >> sh;
            OP_SRA:  lo = a_s >>> sh;
            OP_SLT:  lo = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: lo = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
`ifdef SEQ_ALU_FAST_MUL_EN
            OP_MULU, OP_MULS: {hi, lo} = prod;
`endif
            OP_DIVU: begin
                // Only a zero divisor reaches EXEC.
                hi                   = a_q;
                lo                   = '1;
                exec_flags[FLAG_ERR] = 1'b1;
            end
            OP_ROTL: lo = rot[2*WIDTH-1:WIDTH];
            default: exec_flags[FLAG_ERR] = 1'b1;
        endcase
        exec_flags[FLAG_ZERO] = ({hi, lo} == '0);
    end

    // Result and flag registers, held through DONE until the consumer takes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result  <= '0;
            flags_q <= '0;
        end else if (state == S_EXEC) begin
            result  <= {hi, lo};
            flags_q <= exec_flags;
        end else if ((state == S_MUL || state == S_DIV) && iter_done) begin
            result  <= iter_res;
            flags_q <= iter_flags;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard testbench for seq_alu (WIDTH=32). Expected responses come from
// an arithmetic reference model and are pushed at acceptance; a monitor pops
// and compares them when the DUT presents a result.
module tb_seq_alu;

    localparam int WIDTH = 32;
    localparam int OPW   = 5;
`ifdef SEQ_ALU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = WIDTH + 2;
`endif
    localparam int DIV_LAT = WIDTH + 2;

    typedef struct packed {
        logic [63:0] res;
        logic        zero;
        logic        carry;
        logic        ovf;
        logic        err;
        logic [31:0] due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        flag_zero, flag_carry, flag_ovf, flag_err;

    logic        bp_en;
    logic        ready_ctl;
    logic        rnd_ready;
    assign out_ready = bp_en ? rnd_ready : ready_ctl;

    exp_t        sb[$];
    int          cyc;
    int          checks;
    int          failures;
    logic        presenting;
    logic [67:0] held;

    seq_alu #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf),
        .flag_err   (flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: the specification's rules in plain integer arithmetic.
    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t             e;
        int               sx, sy;
        longint           wide;
        longint unsigned  uw;
        logic [4:0]       s;
        e    = '0;
        sx   = int'(x);
        sy   = int'(y);
        s    = y[4:0];
        case (o)
            5'd0: begin
                e.res   = {32'd0, x + y};
                uw      = longint'(x) + longint'(y);
                e.carry = (uw > 64'hFFFF_FFFF);
                wide    = longint'(sx) + longint'(sy);
                e.ovf   = (wide != longint'(int'(x + y)));
            end
            5'd1: begin
                e.res   = {32'd0, x - y};
                e.carry = (x < y);
                wide    = longint'(sx) - longint'(sy);
                e.ovf   = (wide != longint'(int'(x - y)));
            end
            5'd2:  e.res = {32'd0, x & y};
            5'd3:  e.res = {32'd0, x | y};
            5'd4:  e.res = {32'd0, x ^ y};
            5'd5:  e.res = {32'd0, ~(x | y)};
            5'd6:  e.res = {32'd0, x << s};
            5'd7:  e.res = {32'd0, x >> s};
            5'd8:  e.res = {32'd0, 32'(sx >>> s)};
            5'd9:  e.res = (sx < sy) ? 64'd1 : 64'd0;
            5'd10: e.res = (x < y) ? 64'd1 : 64'd0;
            5'd11: e.res = 64'(x) * 64'(y);
            5'd12: e.res = 64'(longint'(sx) * longint'(sy));
            5'd13: begin
                if (y == 32'd0) begin
                    e.res = {x, 32'hFFFF_FFFF};
                    e.err = 1'b1;
                end else begin
                    e.res = {x % y, x / y};
                end
            end
            5'd14: e.res = {32'd0, (x << s) | (x >> (6'd32 - {1'b0, s}))};
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 64'd0);
        return e;
    endfunction

    function automatic int latency(input logic [4:0] o, input logic [31:0] y);
        if (o == 5'd13 && y != 32'd0) return DIV_LAT;
        if (o == 5'd11 || o == 5'd12) return MUL_LAT;
        return 2;
    endfunction

    // Monitor: compare on first presentation, then check hold stability until taken.
    initial presenting = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            presenting = 1'b0;
        end else if (out_valid === 1'b1) begin
            if (!presenting) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result: got %h with no pending operation (cycle %0d)", result, cyc);
                end else begin
                    e = sb[0];
                    check64("result", result, e.res);
                    check64("flags_zcoe", 64'({flag_zero, flag_carry, flag_ovf, flag_err}),
                            64'({e.zero, e.carry, e.ovf, e.err}));
                    check64("latency_edge", 64'(cyc + 1), 64'(e.due));
                end
                presenting = 1'b1;
                held = {result, flag_zero, flag_carry, flag_ovf, flag_err};
            end else begin
                check64("hold_stable", 64'({result, flag_zero, flag_carry, flag_ovf, flag_err} != held), 64'd0);
            end
            check64("in_ready_in_done", 64'(in_ready), 64'(out_ready));
            if (out_ready === 1'b1) begin
                presenting = 1'b0;
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end
    end

    // Offer one operation (called at posedge+1), wait for acceptance, push its expectation.
    task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, output int waited);
        exp_t e;
        bit   ok;
        ok       = 1'b0;
        waited   = 0;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=%b required 1 within 300 cycles (op %0d)", in_ready, o);
        end else begin
            e     = model(o, x, y);
            e.due = 32'(cyc + 1 + latency(o, y));
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op       = 5'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !presenting) break;
        end
        check64("drain_pending", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        bp_en     = 1'b0;
        ready_ctl = 1'b1;

        // Reset behaviour
        @(negedge clk);
        check64("in_ready_during_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check64("reset_in_ready", 64'(in_ready), 64'd1);
        check64("reset_out_valid", 64'(out_valid), 64'd0);
        check64("reset_result", result, 64'd0);
        check64("reset_flags", 64'({flag_zero, flag_carry, flag_ovf, flag_err}), 64'd0);
        @(posedge clk);
        #1;

        // Directed ADD, then every legal opcode on the same operands
        send(5'd0, 32'h0000_000A, 32'h0000_0002, w);
        for (int o = 0; o <= 14; o++) send(5'(o), 32'h0000_000A, 32'h0000_0002, w);
        wait_idle();

        // Multiply, divide and boundary cases
        send(5'd12, 32'hFFFF_FFF6, 32'h0000_000A, w);
        send(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        send(5'd12, 32'h8000_0000, 32'h8000_0000, w);
        send(5'd13, 32'h0000_00F6, 32'h0000_000A, w);
        send(5'd13, 32'h0000_00F6, 32'h0000_0000, w);
        send(5'd0,  32'h7FFF_FFFF, 32'h0000_0001, w);
        send(5'd1,  32'h0000_0000, 32'h0000_0001, w);
        send(5'd20, 32'h1234_5678, 32'h9ABC_DEF0, w);
        send(5'd14, 32'h8000_0001, 32'h0000_001F, w);
        send(5'd8,  32'h8000_0000, 32'h0000_001F, w);
        wait_idle();

        // Hold in DONE with a queued operation, then release
        ready_ctl = 1'b0;
        send(5'd0, 32'h0000_0005, 32'h0000_0007, w);
        op       = 5'd4;
        a        = 32'hF0F0_F0F0;
        b        = 32'h0FF0_0FF0;
        in_valid = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        ready_ctl = 1'b1;
        send(5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, w);
        check64("queued_accept_wait", 64'(w), 64'd0);
        wait_idle();

        // Reset in the middle of an iterative multiply
        send(5'd11, 32'h0001_2345, 32'h0000_6789, w);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check64("midop_reset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check64("after_midop_in_ready", 64'(in_ready), 64'd1);
        check64("after_midop_out_valid", 64'(out_valid), 64'd0);
        check64("after_midop_result", result, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        send(5'd0, 32'h0000_0003, 32'h0000_0004, w);
        wait_idle();

        // Randomized traffic with consumer backpressure
        bp_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [4:0]  ro;
            logic [31:0] rx, ry;
            ro = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
            rx = pick();
            ry = pick();
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            send(ro, rx, ry, w);
        end
        wait_idle();
        bp_en = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
